control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Hardwired Moore control unit that replaces the hand-driven control waveforms currently applied to `bus` in the datapath benches. It sits directly upstream of `bus` and drives every datapath control line.
- Each instruction runs as a fetch sequence (T0 to T2) followed by a per-opcode execute sequence (T3 to T7), one state per clock.
- It decodes the IR value fed back from the datapath and samples the CON flip-flop for branches.

Parameters:
- ALU_W, 12, width of the one-hot ALUControl bus
- OP_W, 5, opcode width, taken from IR[31:27]

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  asynchronous, active-low reset
- IR  in  32  instruction register contents; opcode is IR[31:27]
- CON  in  1  branch-condition flip-flop output
- Run  out  1  high while executing; low after halt
- PCout, PCin, MARin, IncPC, Zin, Zlowout, Zhighout, Yin  out  1 each  PC, MAR, Y and Z strobes
- MDRin, MDRout, MDRRead, RAMwrite, IRin  out  1 each  memory-path strobes
- HIin, HIout, LOin, LOout  out  1 each  HI/LO strobes
- Gra, Grb, Grc, Rin_in, Rout_in, BAout, r15write  out  1 each  register select and enables
- Cout, CONin, con_FF_Reset, InPortout, OutPortIn  out  1 each  immediate, condition and I/O strobes
- ALUControl  out  ALU_W  one-hot operation select
  - bit0 add, bit1 sub, bit2 and, bit3 or, bit4 shr, bit5 shl, bit6 ror, bit7 rol, bit8 mul, bit9 div, bit10 neg, bit11 not

Behaviour:
- Reset:
  - clr low puts the FSM in RST asynchronously.
  - All outputs are 0 in RST, including Run and ALUControl.
  - The first rising edge after clr goes high moves RST to T0.
- Output style: outputs decode combinationally from the state register and the latched opcode only, so they are glitch-free relative to clk. Any output not listed for a state is 0.
- Fetch:
  - T0: PCout, MARin, IncPC, Zin, con_FF_Reset.
  - T1: Zlowout, PCin, MDRRead, MDRin.
  - T2: MDRout, IRin.
  - The opcode is latched from IR at the T3 entry edge.
- Execute, by opcode (steps are T3, T4, ... in order):
  - ld 00000: Grb,BAout,Yin; Cout,add,Zin; Zlowout,MARin; MDRRead,MDRin; MDRout,Gra,Rin_in.
  - ldi 00001: Grb,BAout,Yin; Cout,add,Zin; Zlowout,Gra,Rin_in.
  - st 00010: Grb,BAout,Yin; Cout,add,Zin; Zlowout,MARin; Gra,Rout_in,MDRin (MDRRead=0); RAMwrite.
  - R-ALU add..rol, and, or (00011–01010): Grb,Rout_in,Yin; Grc,Rout_in,op,Zin; Zlowout,Gra,Rin_in.
  - addi/andi/ori (01011–01101): as R-ALU, but T4 uses Cout instead of Grc,Rout_in.
  - mul/div (01110, 01111): Gra,Rout_in,Yin; Grb,Rout_in,op,Zin; Zlowout,LOin; Zhighout,HIin.
  - neg/not (10000, 10001): Grb,Rout_in,op,Zin; Zlowout,Gra,Rin_in.
  - br 10010: Gra,Rout_in,CONin; PCout,Yin; Cout,add,Zin; then T6: if CON is 1, Zlowout,PCin, else no strobes.
    - CON is sampled in T6, not earlier.
  - jr 10011: Gra,Rout_in,PCin.
  - jal 10100: PCout,r15write; Gra,Rout_in,PCin.
  - in 10101: InPortout,Gra,Rin_in.
  - out 10110: Gra,Rout_in,OutPortIn.
  - mfhi 10111: HIout,Gra,Rin_in. mflo 11000: LOout,Gra,Rin_in.
  - nop 11001: T2 goes directly to T0.
- Sequence exit: after the last step of any sequence, the next state is T0.
- Latency: fetch is 3 cycles. Total cycles per instruction: ld/st 8, ldi/ALU/mul/div/br 6–7, nop 3, jr/in/out/mf* 4.
- Halt:
  - halt 11010: T3 goes to HALT. Run=0 and all strobes are 0.
  - HALT is held until clr is asserted.
- Illegal opcodes (11011–11111) execute as nop.
- Run is 1 in every state except RST and HALT.
- clr asserted mid-instruction aborts the sequence at once, with no partial writes beyond the current cycle. The next instruction fetch starts at T0.

Decomposition:
- Shared package cpu_ctrl_pkg holds:
  - opcode_t, a 5-bit enum with all 27 opcodes;
  - state_t, the enum RST, T0–T7, HALT;
  - ALU one-hot localparams ALU_ADD … ALU_NOT.
- Optional sub-module ctrl_out_decode: combinational, maps (state_t, opcode_t, CON) to the output strobes, keeping the FSM itself small.

Test Plan:
- Reset: clr low for 2 cycles, then high. Require all outputs 0 during reset, and PCout=MARin=IncPC=Zin=1 on the first cycle after release.
- ldi r2,0x65 with IR=0x09000065: T3 Grb,BAout,Yin; T4 Cout, ALUControl=12'h001, Zin; T5 Zlowout,Gra,Rin_in. Next cycle is T0 (6 cycles total).
- addi r2,r1,-5 with IR=0x590FFFFB: T3 Grb,Rout_in,Yin; T4 Cout, ALUControl=12'h001, Zin; T5 Zlowout,Gra,Rin_in.
- br with IR opcode 10010:
  - CON=1 in T6 requires Zlowout=PCin=1.
  - Repeat with CON=0: T6 has no strobes, and T0 follows.
- mul (opcode 01110): T4 ALUControl=12'h100; T5 Zlowout,LOin; T6 Zhighout,HIin. Then halt (IR[31:27]=11010): Run falls at HALT entry and stays 0 for 20 cycles.
- Abort and fallback cases:
  - Assert clr during T6 of an ld: all outputs 0 asynchronously, and a fresh fetch follows release.
  - Illegal opcode 11111: behaves as nop, 3 cycles.

Source files
------------

// File: rtl/cpu_ctrl_pkg.sv
// Shared types and constants for the hardwired control sequencer.
//   opcode_t : 5-bit instruction opcode (IR[31:27]); 11011-11111 are unassigned
//   state_t  : sequencer timing states RST, T0-T7, HALT
//   ctrl_t   : bundle of every datapath control line driven by the sequencer
//   ALU_*    : one-hot ALUControl encodings
package cpu_ctrl_pkg;

    localparam int CTRL_ALU_W = 12;
    localparam int CTRL_OP_W  = 5;

    typedef enum logic [4:0] {
        OP_LD   = 5'b00000,
        OP_LDI  = 5'b00001,
        OP_ST   = 5'b00010,
        OP_ADD  = 5'b00011,
        OP_SUB  = 5'b00100,
        OP_AND  = 5'b00101,
        OP_OR   = 5'b00110,
        OP_SHR  = 5'b00111,
        OP_SHL  = 5'b01000,
        OP_ROR  = 5'b01001,
        OP_ROL  = 5'b01010,
        OP_ADDI = 5'b01011,
        OP_ANDI = 5'b01100,
        OP_ORI  = 5'b01101,
        OP_MUL  = 5'b01110,
        OP_DIV  = 5'b01111,
        OP_NEG  = 5'b10000,
        OP_NOT  = 5'b10001,
        OP_BR   = 5'b10010,
        OP_JR   = 5'b10011,
        OP_JAL  = 5'b10100,
        OP_IN   = 5'b10101,
        OP_OUT  = 5'b10110,
        OP_MFHI = 5'b10111,
        OP_MFLO = 5'b11000,
        OP_NOP  = 5'b11001,
        OP_HALT = 5'b11010
    } opcode_t;

    typedef enum logic [3:0] {
        RST  = 4'd0,
        T0   = 4'd1,
        T1   = 4'd2,
        T2   = 4'd3,
        T3   = 4'd4,
        T4   = 4'd5,
        T5   = 4'd6,
        T6   = 4'd7,
        T7   = 4'd8,
        HALT = 4'd9
    } state_t;

    localparam logic [CTRL_ALU_W-1:0] ALU_ADD = 12'h001;
    localparam logic [CTRL_ALU_W-1:0] ALU_SUB = 12'h002;
    localparam logic [CTRL_ALU_W-1:0] ALU_AND = 12'h004;
    localparam logic [CTRL_ALU_W-1:0] ALU_OR  = 12'h008;
    localparam logic [CTRL_ALU_W-1:0] ALU_SHR = 12'h010;
    localparam logic [CTRL_ALU_W-1:0] ALU_SHL = 12'h020;
    localparam logic [CTRL_ALU_W-1:0] ALU_ROR = 12'h040;
    localparam logic [CTRL_ALU_W-1:0] ALU_ROL = 12'h080;
    localparam logic [CTRL_ALU_W-1:0] ALU_MUL = 12'h100;
    localparam logic [CTRL_ALU_W-1:0] ALU_DIV = 12'h200;
    localparam logic [CTRL_ALU_W-1:0] ALU_NEG = 12'h400;
    localparam logic [CTRL_ALU_W-1:0] ALU_NOT = 12'h800;

    typedef struct packed {
        logic                  run;
        logic [CTRL_ALU_W-1:0] alu;
        logic pc_out, pc_in, mar_in, inc_pc, z_in, zlow_out, zhigh_out, y_in;
        logic mdr_in, mdr_out, mdr_read, ram_write, ir_in;
        logic hi_in, hi_out, lo_in, lo_out;
        logic gra, grb, grc, rin_in, rout_in, ba_out, r15_write;
        logic c_out, con_in, con_ff_reset, inport_out, outport_in;
    } ctrl_t;

    // ALU operation for the opcodes that route through the ALU; immediates
    // reuse the register-form operation.
    function automatic logic [CTRL_ALU_W-1:0] alu_sel(input opcode_t op);
        logic [CTRL_ALU_W-1:0] sel;
        sel = '0;
        case (op)
            OP_ADD, OP_ADDI: sel = ALU_ADD;
            OP_SUB:          sel = ALU_SUB;
            OP_AND, OP_ANDI: sel = ALU_AND;
            OP_OR,  OP_ORI:  sel = ALU_OR;
            OP_SHR:          sel = ALU_SHR;
            OP_SHL:          sel = ALU_SHL;
            OP_ROR:          sel = ALU_ROR;
            OP_ROL:          sel = ALU_ROL;
            OP_MUL:          sel = ALU_MUL;
            OP_DIV:          sel = ALU_DIV;
            OP_NEG:          sel = ALU_NEG;
            OP_NOT:          sel = ALU_NOT;
            default:         sel = '0;
        endcase
        return sel;
    endfunction

    // Final execute step of each opcode's sequence.
    function automatic state_t last_step(input opcode_t op);
        state_t s;
        case (op)
            OP_LD, OP_ST:                      s = T7;
            OP_MUL, OP_DIV, OP_BR:             s = T6;
            OP_LDI, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL,
            OP_ROR, OP_ROL, OP_ADDI, OP_ANDI, OP_ORI: s = T5;
            OP_NEG, OP_NOT, OP_JAL:            s = T4;
            default:                           s = T3;
        endcase
        return s;
    endfunction

    // Opcodes that skip execute entirely: nop and every unassigned code.
    function automatic logic is_nop_like(input logic [CTRL_OP_W-1:0] op);
        return (op == OP_NOP) || (op > OP_HALT);
    endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// Combinational output decoder for the control sequencer.
//   state  : current sequencer state
//   opcode : opcode latched on entry to T3
//   con    : branch-condition flip-flop, only consulted in br T6
//   ctrl   : every datapath control line, all zero unless named for the state
module ctrl_out_decode
    import cpu_ctrl_pkg::*;
(
    input  state_t  state,
    input  opcode_t opcode,
    input  logic    con,
    output ctrl_t   ctrl
);

    logic is_alu_imm;

    assign is_alu_imm = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);

    always_comb begin
        ctrl     = '0;
        ctrl.run = (state != RST) && (state != HALT);
        case (state)
            T0: begin
                ctrl.pc_out       = 1'b1;
                ctrl.mar_in       = 1'b1;
                ctrl.inc_pc       = 1'b1;
                ctrl.z_in         = 1'b1;
                ctrl.con_ff_reset = 1'b1;
            end
            T1: begin
                ctrl.zlow_out = 1'b1;
                ctrl.pc_in    = 1'b1;
                ctrl.mdr_read = 1'b1;
                ctrl.mdr_in   = 1'b1;
            end
            T2: begin
                ctrl.mdr_out = 1'b1;
                ctrl.ir_in   = 1'b1;
            end
            T3, T4, T5, T6, T7: begin
                case (opcode)
                    OP_LD, OP_LDI, OP_ST: begin
                        case (state)
                            T3: begin
                                ctrl.grb    = 1'b1;
                                ctrl.ba_out = 1'b1;
                                ctrl.y_in   = 1'b1;
                            end
                            T4: begin
                                ctrl.c_out = 1'b1;
                                ctrl.alu   = ALU_ADD;
                                ctrl.z_in  = 1'b1;
                            end
                            T5: begin
                                ctrl.zlow_out = 1'b1;
                                if (opcode == OP_LDI) begin
                                    ctrl.gra    = 1'b1;
                                    ctrl.rin_in = 1'b1;
                                end else begin
                                    ctrl.mar_in = 1'b1;
                                end
                            end
                            T6: begin
                                if (opcode == OP_LD) begin
                                    ctrl.mdr_read = 1'b1;
                                    ctrl.mdr_in   = 1'b1;
                                end else if (opcode == OP_ST) begin
                                    // Store data comes from the register file, not memory.
                                    ctrl.gra     = 1'b1;
                                    ctrl.rout_in = 1'b1;
                                    ctrl.mdr_in  = 1'b1;
                                end
                            end
                            T7: begin
                                if (opcode == OP_LD) begin
                                    ctrl.mdr_out = 1'b1;
                                    ctrl.gra     = 1'b1;
                                    ctrl.rin_in  = 1'b1;
                                end else if (opcode == OP_ST) begin
                                    ctrl.ram_write = 1'b1;
                                end
                            end
                            default: ;
                        endcase
                    end
                    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR, OP_SHL, OP_ROR, OP_ROL,
                    OP_ADDI, OP_ANDI, OP_ORI: begin
                        case (state)
                            T3: begin
                                ctrl.grb     = 1'b1;
                                ctrl.rout_in = 1'b1;
                                ctrl.y_in    = 1'b1;
                            end
                            T4: begin
                                ctrl.alu  = alu_sel(opcode);
                                ctrl.z_in = 1'b1;
                                if (is_alu_imm) begin
                                    ctrl.c_out = 1'b1;
                                end else begin
                                    ctrl.grc     = 1'b1;
                                    ctrl.rout_in = 1'b1;
                                end
                            end
                            T5: begin
                                ctrl.zlow_out = 1'b1;
                                ctrl.gra      = 1'b1;
                                ctrl.rin_in   = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_MUL, OP_DIV: begin
                        case (state)
                            T3: begin
                                ctrl.gra     = 1'b1;
                                ctrl.rout_in = 1'b1;
                                ctrl.y_in    = 1'b1;
                            end
                            T4: begin
                                ctrl.grb     = 1'b1;
                                ctrl.rout_in = 1'b1;
                                ctrl.alu     = alu_sel(opcode);
                                ctrl.z_in    = 1'b1;
                            end
                            T5: begin
                                ctrl.zlow_out = 1'b1;
                                ctrl.lo_in    = 1'b1;
                            end
                            T6: begin
                                ctrl.zhigh_out = 1'b1;
                                ctrl.hi_in     = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_NEG, OP_NOT: begin
                        case (state)
                            T3: begin
                                ctrl.grb     = 1'b1;
                                ctrl.rout_in = 1'b1;
                                ctrl.alu     = alu_sel(opcode);
                                ctrl.z_in    = 1'b1;
                            end
                            T4: begin
                                ctrl.zlow_out = 1'b1;
                                ctrl.gra      = 1'b1;
                                ctrl.rin_in   = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    OP_BR: begin
                        case (state)
                            T3: begin
                                ctrl.gra     = 1'b1;
                                ctrl.rout_in = 1'b1;
                                ctrl.con_in  = 1'b1;
                            end
                            T4: begin
                                ctrl.pc_out = 1'b1;
                                ctrl.y_in   = 1'b1;
                            end
                            T5: begin
                                ctrl.c_out = 1'b1;
                                ctrl.alu   = ALU_ADD;
                                ctrl.z_in  = 1'b1;
                            end
                            T6: begin
                                // CON was loaded in T3; it is settled by now.
                                ctrl.zlow_out = con;
                                ctrl.pc_in    = con;
                            end
                            default: ;
                        endcase
                    end
                    OP_JR: begin
                        if (state == T3) begin
                            ctrl.gra     = 1'b1;
                            ctrl.rout_in = 1'b1;
                            ctrl.pc_in   = 1'b1;
                        end
                    end
                    OP_JAL: begin
                        if (state == T3) begin
                            ctrl.pc_out    = 1'b1;
                            ctrl.r15_write = 1'b1;
                        end else if (state == T4) begin
                            ctrl.gra     = 1'b1;
                            ctrl.rout_in = 1'b1;
                            ctrl.pc_in   = 1'b1;
                        end
                    end
                    OP_IN: begin
                        if (state == T3) begin
                            ctrl.inport_out = 1'b1;
                            ctrl.gra        = 1'b1;
                            ctrl.rin_in     = 1'b1;
                        end
                    end
                    OP_OUT: begin
                        if (state == T3) begin
                            ctrl.gra        = 1'b1;
                            ctrl.rout_in    = 1'b1;
                            ctrl.outport_in = 1'b1;
                        end
                    end
                    OP_MFHI: begin
                        if (state == T3) begin
                            ctrl.hi_out = 1'b1;
                            ctrl.gra    = 1'b1;
                            ctrl.rin_in = 1'b1;
                        end
                    end
                    OP_MFLO: begin
                        if (state == T3) begin
                            ctrl.lo_out = 1'b1;
                            ctrl.gra    = 1'b1;
                            ctrl.rin_in = 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit driving every datapath control line.
//   clk        : rising-edge clock
//   clr        : asynchronous active-low reset
//   IR         : instruction register contents, opcode in IR[31:27]
//   CON        : branch-condition flip-flop
//   Run        : high while executing, low in RST and HALT
//   ALUControl : one-hot ALU operation select
//   remaining outputs : single-bit datapath strobes
//
// state | meaning
// RST   | held in reset, all outputs 0
// T0    | PC to MAR, PC+1 into Z
// T1    | Z to PC, memory read into MDR
// T2    | MDR to IR; nop/unassigned opcodes return to T0
// T3-T7 | per-opcode execute steps; last step returns to T0
// HALT  | stopped after halt, only clr leaves
module control_sequencer
    import cpu_ctrl_pkg::*;
#(
    parameter int ALU_W = CTRL_ALU_W,
    parameter int OP_W  = CTRL_OP_W
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [31:0]      IR,
    input  logic             CON,
    output logic             Run,
    output logic             PCout,
    output logic             PCin,
    output logic             MARin,
    output logic             IncPC,
    output logic             Zin,
    output logic             Zlowout,
    output logic             Zhighout,
    output logic             Yin,
    output logic             MDRin,
    output logic             MDRout,
    output logic             MDRRead,
    output logic             RAMwrite,
    output logic             IRin,
    output logic             HIin,
    output logic             HIout,
    output logic             LOin,
    output logic             LOout,
    output logic             Gra,
    output logic             Grb,
    output logic             Grc,
    output logic             Rin_in,
    output logic             Rout_in,
    output logic             BAout,
    output logic             r15write,
    output logic             Cout,
    output logic             CONin,
    output logic             con_FF_Reset,
    output logic             InPortout,
    output logic             OutPortIn,
    output logic [ALU_W-1:0] ALUControl
);

    state_t            state, state_nxt;
    opcode_t           opcode_q;
    logic [OP_W-1:0]   ir_op;
    logic              unused_ir;
    ctrl_t             ctrl;

    assign ir_op     = IR[31 -: OP_W];
    assign unused_ir = ^IR[31-OP_W:0];

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= RST;
            opcode_q <= OP_NOP;
        end else begin
            state <= state_nxt;
            // Latch on the T2->T3 edge so execute outputs depend only on registers.
            if (state == T2) begin
                opcode_q <= opcode_t'(ir_op);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            RST:  state_nxt = T0;
            T0:   state_nxt = T1;
            T1:   state_nxt = T2;
            T2:   state_nxt = is_nop_like(ir_op) ? T0 : T3;
            T3: begin
                if (opcode_q == OP_HALT) begin
                    state_nxt = HALT;
                end else if (last_step(opcode_q) == T3) begin
                    state_nxt = T0;
                end else begin
                    state_nxt = T4;
                end
            end
            T4:   state_nxt = (last_step(opcode_q) == T4) ? T0 : T5;
            T5:   state_nxt = (last_step(opcode_q) == T5) ? T0 : T6;
            T6:   state_nxt = (last_step(opcode_q) == T6) ? T0 : T7;
            T7:   state_nxt = T0;
            HALT: state_nxt = HALT;
            default: state_nxt = RST;
        endcase
    end

    ctrl_out_decode u_decode (
        .state  (state),
        .opcode (opcode_q),
        .con    (CON),
        .ctrl   (ctrl)
    );

    assign Run          = ctrl.run;
    assign ALUControl   = ctrl.alu;
    assign PCout        = ctrl.pc_out;
    assign PCin         = ctrl.pc_in;
    assign MARin        = ctrl.mar_in;
    assign IncPC        = ctrl.inc_pc;
    assign Zin          = ctrl.z_in;
    assign Zlowout      = ctrl.zlow_out;
    assign Zhighout     = ctrl.zhigh_out;
    assign Yin          = ctrl.y_in;
    assign MDRin        = ctrl.mdr_in;
    assign MDRout       = ctrl.mdr_out;
    assign MDRRead      = ctrl.mdr_read;
    assign RAMwrite     = ctrl.ram_write;
    assign IRin         = ctrl.ir_in;
    assign HIin         = ctrl.hi_in;
    assign HIout        = ctrl.hi_out;
    assign LOin         = ctrl.lo_in;
    assign LOout        = ctrl.lo_out;
    assign Gra          = ctrl.gra;
    assign Grb          = ctrl.grb;
    assign Grc          = ctrl.grc;
    assign Rin_in       = ctrl.rin_in;
    assign Rout_in      = ctrl.rout_in;
    assign BAout        = ctrl.ba_out;
    assign r15write     = ctrl.r15_write;
    assign Cout         = ctrl.c_out;
    assign CONin        = ctrl.con_in;
    assign con_FF_Reset = ctrl.con_ff_reset;
    assign InPortout    = ctrl.inport_out;
    assign OutPortIn    = ctrl.outport_in;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each instruction pushes its
// per-cycle expected output vector; vectors are popped and compared on
// the falling edge as the sequencer steps through its states.
module tb_control_sequencer;

    typedef logic [41:0] vec_t;

    localparam vec_t B_PCOUT    = 42'd1 << 0;
    localparam vec_t B_PCIN     = 42'd1 << 1;
    localparam vec_t B_MARIN    = 42'd1 << 2;
    localparam vec_t B_INCPC    = 42'd1 << 3;
    localparam vec_t B_ZIN      = 42'd1 << 4;
    localparam vec_t B_ZLOWOUT  = 42'd1 << 5;
    localparam vec_t B_ZHIGHOUT = 42'd1 << 6;
    localparam vec_t B_YIN      = 42'd1 << 7;
    localparam vec_t B_MDRIN    = 42'd1 << 8;
    localparam vec_t B_MDROUT   = 42'd1 << 9;
    localparam vec_t B_MDRREAD  = 42'd1 << 10;
    localparam vec_t B_RAMWRITE = 42'd1 << 11;
    localparam vec_t B_IRIN     = 42'd1 << 12;
    localparam vec_t B_HIIN     = 42'd1 << 13;
    localparam vec_t B_HIOUT    = 42'd1 << 14;
    localparam vec_t B_LOIN     = 42'd1 << 15;
    localparam vec_t B_LOOUT    = 42'd1 << 16;
    localparam vec_t B_GRA      = 42'd1 << 17;
    localparam vec_t B_GRB      = 42'd1 << 18;
    localparam vec_t B_GRC      = 42'd1 << 19;
    localparam vec_t B_RININ    = 42'd1 << 20;
    localparam vec_t B_ROUTIN   = 42'd1 << 21;
    localparam vec_t B_BAOUT    = 42'd1 << 22;
    localparam vec_t B_R15W     = 42'd1 << 23;
    localparam vec_t B_COUT     = 42'd1 << 24;
    localparam vec_t B_CONIN    = 42'd1 << 25;
    localparam vec_t B_CONFFR   = 42'd1 << 26;
    localparam vec_t B_INPORT   = 42'd1 << 27;
    localparam vec_t B_OUTPORT  = 42'd1 << 28;
    localparam vec_t A_ADD      = 42'h001 << 29;
    localparam vec_t A_SUB      = 42'h002 << 29;
    localparam vec_t A_MUL      = 42'h100 << 29;
    localparam vec_t A_NEG      = 42'h400 << 29;
    localparam vec_t B_RUN      = 42'd1 << 41;

    localparam logic [4:0] C_LD   = 5'b00000;
    localparam logic [4:0] C_LDI  = 5'b00001;
    localparam logic [4:0] C_SUB  = 5'b00100;
    localparam logic [4:0] C_ADDI = 5'b01011;
    localparam logic [4:0] C_MUL  = 5'b01110;
    localparam logic [4:0] C_NEG  = 5'b10000;
    localparam logic [4:0] C_BR   = 5'b10010;
    localparam logic [4:0] C_JAL  = 5'b10100;
    localparam logic [4:0] C_MFHI = 5'b10111;
    localparam logic [4:0] C_NOP  = 5'b11001;
    localparam logic [4:0] C_HALT = 5'b11010;
    localparam logic [4:0] C_ILL  = 5'b11111;

    logic        clk, clr, CON;
    logic [31:0] IR;
    logic Run, PCout, PCin, MARin, IncPC, Zin, Zlowout, Zhighout, Yin;
    logic MDRin, MDRout, MDRRead, RAMwrite, IRin, HIin, HIout, LOin, LOout;
    logic Gra, Grb, Grc, Rin_in, Rout_in, BAout, r15write;
    logic Cout, CONin, con_FF_Reset, InPortout, OutPortIn;
    logic [11:0] ALUControl;

    typedef struct {
        string tag;
        vec_t  v;
    } exp_t;

    exp_t sb[$];
    int   n_vec  = 0;
    int   n_miss = 0;
    vec_t obs;

    control_sequencer dut (
        .clk(clk), .clr(clr), .IR(IR), .CON(CON), .Run(Run),
        .PCout(PCout), .PCin(PCin), .MARin(MARin), .IncPC(IncPC), .Zin(Zin),
        .Zlowout(Zlowout), .Zhighout(Zhighout), .Yin(Yin),
        .MDRin(MDRin), .MDRout(MDRout), .MDRRead(MDRRead), .RAMwrite(RAMwrite), .IRin(IRin),
        .HIin(HIin), .HIout(HIout), .LOin(LOin), .LOout(LOout),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin_in(Rin_in), .Rout_in(Rout_in),
        .BAout(BAout), .r15write(r15write), .Cout(Cout), .CONin(CONin),
        .con_FF_Reset(con_FF_Reset), .InPortout(InPortout), .OutPortIn(OutPortIn),
        .ALUControl(ALUControl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obs = {Run, ALUControl, OutPortIn, InPortout, con_FF_Reset, CONin, Cout,
                  r15write, BAout, Rout_in, Rin_in, Grc, Grb, Gra, LOout, LOin,
                  HIout, HIin, IRin, RAMwrite, MDRRead, MDRout, MDRin, Yin,
                  Zhighout, Zlowout, Zin, IncPC, MARin, PCin, PCout};

    task automatic check_vec(input string tag, input vec_t got, input vec_t want);
        n_vec++;
        if (got !== want) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, want);
        end
    endtask

    task automatic push(input string tag, input vec_t v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sb.push_back(e);
    endtask

    task automatic push_instr(input logic [4:0] op, input logic con);
        vec_t r;
        r = B_RUN;
        push("T0", r | B_PCOUT | B_MARIN | B_INCPC | B_ZIN | B_CONFFR);
        push("T1", r | B_ZLOWOUT | B_PCIN | B_MDRREAD | B_MDRIN);
        push("T2", r | B_MDROUT | B_IRIN);
        case (op)
            C_LD: begin
                push("ld_T3", r | B_GRB | B_BAOUT | B_YIN);
                push("ld_T4", r | B_COUT | A_ADD | B_ZIN);
                push("ld_T5", r | B_ZLOWOUT | B_MARIN);
                push("ld_T6", r | B_MDRREAD | B_MDRIN);
                push("ld_T7", r | B_MDROUT | B_GRA | B_RININ);
            end
            C_LDI: begin
                push("ldi_T3", r | B_GRB | B_BAOUT | B_YIN);
                push("ldi_T4", r | B_COUT | A_ADD | B_ZIN);
                push("ldi_T5", r | B_ZLOWOUT | B_GRA | B_RININ);
            end
            C_SUB: begin
                push("sub_T3", r | B_GRB | B_ROUTIN | B_YIN);
                push("sub_T4", r | B_GRC | B_ROUTIN | A_SUB | B_ZIN);
                push("sub_T5", r | B_ZLOWOUT | B_GRA | B_RININ);
            end
            C_ADDI: begin
                push("addi_T3", r | B_GRB | B_ROUTIN | B_YIN);
                push("addi_T4", r | B_COUT | A_ADD | B_ZIN);
                push("addi_T5", r | B_ZLOWOUT | B_GRA | B_RININ);
            end
            C_MUL: begin
                push("mul_T3", r | B_GRA | B_ROUTIN | B_YIN);
                push("mul_T4", r | B_GRB | B_ROUTIN | A_MUL | B_ZIN);
                push("mul_T5", r | B_ZLOWOUT | B_LOIN);
                push("mul_T6", r | B_ZHIGHOUT | B_HIIN);
            end
            C_NEG: begin
                push("neg_T3", r | B_GRB | B_ROUTIN | A_NEG | B_ZIN);
                push("neg_T4", r | B_ZLOWOUT | B_GRA | B_RININ);
            end
            C_BR: begin
                push("br_T3", r | B_GRA | B_ROUTIN | B_CONIN);
                push("br_T4", r | B_PCOUT | B_YIN);
                push("br_T5", r | B_COUT | A_ADD | B_ZIN);
                push(con ? "br_T6_taken" : "br_T6_not", con ? (r | B_ZLOWOUT | B_PCIN) : r);
            end
            C_JAL: begin
                push("jal_T3", r | B_PCOUT | B_R15W);
                push("jal_T4", r | B_GRA | B_ROUTIN | B_PCIN);
            end
            C_MFHI: push("mfhi_T3", r | B_HIOUT | B_GRA | B_RININ);
            C_HALT: push("halt_T3", r);
            default: ;
        endcase
    endtask

    // Begin the next instruction: the DUT enters T0 at this rising edge.
    task automatic start_instr(input logic [31:0] ir, input logic con);
        @(posedge clk);
        #1;
        IR  = ir;
        CON = con;
        push_instr(ir[31:27], con);
    endtask

    task automatic drain(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            if (sb.size() == 0) break;
            @(negedge clk);
            e = sb.pop_front();
            check_vec(e.tag, obs, e.v);
        end
    endtask

    task automatic run_instr(input logic [31:0] ir, input logic con);
        start_instr(ir, con);
        drain(sb.size());
    endtask

    function automatic logic [31:0] mk_ir(input logic [4:0] op);
        return {op, 27'h0};
    endfunction

    initial begin
        clr = 1'b0;
        IR  = 32'h0;
        CON = 1'b0;
        repeat (2) begin
            @(negedge clk);
            check_vec("reset", obs, '0);
        end
        clr = 1'b1;

        run_instr(32'h0900_0065, 1'b0);           // ldi r2,0x65
        run_instr(32'h590F_FFFB, 1'b0);           // addi r2,r1,-5
        run_instr(mk_ir(C_SUB)  | 32'h0123_4000, 1'b0);
        run_instr(mk_ir(C_BR)   | 32'h0080_0010, 1'b1);
        run_instr(mk_ir(C_BR)   | 32'h0080_0010, 1'b0);
        run_instr(mk_ir(C_NEG), 1'b0);
        run_instr(mk_ir(C_JAL), 1'b0);
        run_instr(mk_ir(C_NOP), 1'b0);
        run_instr(mk_ir(C_MFHI), 1'b0);
        run_instr(mk_ir(C_MUL), 1'b0);

        start_instr(mk_ir(C_HALT), 1'b0);
        for (int i = 0; i < 20; i++) push("halt_hold", '0);
        drain(sb.size());

        // Only clr leaves HALT.
        clr = 1'b0;
        #1 check_vec("halt_clr", obs, '0);
        @(negedge clk);
        clr = 1'b1;

        // Abort ld in T6: outputs drop immediately, fetch restarts at T0.
        start_instr(mk_ir(C_LD), 1'b0);
        drain(7);
        #2 clr = 1'b0;
        #1 check_vec("abort_async", obs, '0);
        sb.delete();
        @(negedge clk);
        check_vec("abort_hold", obs, '0);
        clr = 1'b1;

        run_instr(mk_ir(C_ILL), 1'b0);
        run_instr(mk_ir(C_LD) | 32'h0012_3456, 1'b0);
        run_instr(32'h0900_0065, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
